// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants, occupancy-count type and operation encoding for the DPRAM-backed FWFT FIFO.
package dpram_fifo_ctrl_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 10;
    localparam int AFULL_TH_DEF  = 1016;
    localparam int AEMPTY_TH_DEF = 8;

    typedef logic [ADDR_W_DEF:0] count_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e op_of(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle of the FIFO; almost flags exist only with FIFO_ALMOST_FLAGS_EN.
interface dpram_fifo_ctrl_if
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [ADDR_W:0]   count;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, count, almost_full, almost_empty);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, count, almost_full, almost_empty);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, count);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, count);
`endif
endinterface

// File: rtl/fifo_mem_1024x8.sv
// Simple dual-port storage: one write port, one read port with read enable and registered output, no reset.
module fifo_mem_1024x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Array write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output holds while i_re is low
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around a dual-port RAM; head word comes straight from the RAM read register.
// Optional almost_full/almost_empty outputs are built only when FIFO_ALMOST_FLAGS_EN is defined.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst,
    dpram_fifo_ctrl_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_ren;
    logic [ADDR_W:0]   w_unread;
    logic [ADDR_W:0]   w_count_nxt;
    logic [DATA_W-1:0] w_rdata;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic              r_almost_full;
    logic              r_almost_empty;
`endif

    // Handshake decode, read issue and next occupancy
    always_comb begin
        w_push      = bus.in_valid && r_in_ready;
        w_pop       = r_out_valid && bus.out_ready;
        // Words still in RAM that have not been fetched into the read register
        w_unread    = r_count - {{ADDR_W{1'b0}}, r_out_valid};
        w_ren       = (w_unread != {(ADDR_W+1){1'b0}}) && (!r_out_valid || w_pop) && !rst;
        w_count_nxt = r_count;
        case (op_of(w_push, w_pop))
            OP_PUSH: w_count_nxt = r_count + (ADDR_W+1)'(1);
            OP_POP:  w_count_nxt = r_count - (ADDR_W+1)'(1);
            OP_BOTH: w_count_nxt = r_count;
            OP_IDLE: w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= {ADDR_W{1'b0}};
            r_rd_ptr       <= {ADDR_W{1'b0}};
            r_count        <= {(ADDR_W+1){1'b0}};
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_ren) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < (ADDR_W+1)'(DEPTH));
            if (w_ren) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
`ifdef FIFO_ALMOST_FLAGS_EN
            r_almost_full  <= (w_count_nxt >= (ADDR_W+1)'(AFULL_TH));
            r_almost_empty <= (w_count_nxt <= (ADDR_W+1)'(AEMPTY_TH));
`endif
        end
    end

    fifo_mem_1024x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.in_data),
        .i_re    (w_ren),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = w_rdata;
    assign bus.count     = r_count;
`ifdef FIFO_ALMOST_FLAGS_EN
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomized and directed bench for dpram_fifo_ctrl against a queue-based reference model.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_ctrl_pkg::*;

    localparam int DEPTH = 1 << ADDR_W_DEF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [7:0] model_q [$];
    logic       exp_valid;

    dpram_fifo_ctrl_if bus ();

    dpram_fifo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_state();
        count_t exp_cnt;
        exp_cnt = count_t'(model_q.size());
        check_eq("count", 32'(bus.count), 32'(exp_cnt));
        check_eq("in_ready", 32'(bus.in_ready), 32'(model_q.size() < DEPTH));
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("out_data", 32'(bus.out_data), 32'(model_q[0]));
        end
`ifdef FIFO_ALMOST_FLAGS_EN
        check_eq("almost_full", 32'(bus.almost_full), 32'(model_q.size() >= AFULL_TH_DEF));
        check_eq("almost_empty", 32'(bus.almost_empty), 32'(model_q.size() <= AEMPTY_TH_DEF));
`endif
    endtask

    // Called at a falling edge: check the state left by the last rising edge, drive, advance the model.
    task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy, input logic rs);
        bit push;
        bit pop;
        bit nv;
        check_state();
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        rst           = rs;
        if (rs) begin
            model_q.delete();
            exp_valid = 1'b0;
        end else begin
            push = iv && (model_q.size() < DEPTH);
            pop  = ordy && exp_valid;
            // A head word is visible next cycle iff a word pushed on an earlier edge survives this pop
            nv   = (model_q.size() - int'(pop)) > 0;
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(d);
            exp_valid = nv;
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        exp_valid     = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single word into empty FIFO: visible two cycles later
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to capacity, then offer extra words that must be ignored
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 8'hEE, 1'b0, 1'b0);

        // Drain across the pointer wrap
        for (int i = 0; i < DEPTH + 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Steady stream with a small prefill
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) cyc(1'b1, 8'($urandom), 1'b1, 1'b0);

        // Stall the consumer with a valid head word
        repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset with ten words stored, then the first post-reset word must come out next
        repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b1, 1'b1);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic, biased toward filling then toward draining
        for (int i = 0; i < 4000; i++) begin
            if (i < 2000) begin
                cyc(1'b1 && ($urandom_range(0, 3) != 0), 8'($urandom),
                    $urandom_range(0, 3) == 0, 1'b0);
            end else begin
                cyc($urandom_range(0, 3) == 0, 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
            end
        end
        repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check_state();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, storage address width (depth 2**ADDR_W = 1024).
REQ-003 The block SHALL have parameter AFULL_TH, default 1016, almost-full threshold in words.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 8, almost-empty threshold in words.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 The block SHALL have port in_valid, input, 1, producer offers in_data.
REQ-008 The block SHALL have port in_data, input, DATA_W, write word.
REQ-009 The block SHALL have port in_ready, output, 1, FIFO can accept a word.
REQ-010 The block SHALL have port out_valid, output, 1, out_data holds the head word.
REQ-011 The block SHALL have port out_data, output, DATA_W, head word, driven directly from the storage read register.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes the head word.
REQ-013 The block SHALL have port count, output, ADDR_W+1, total occupancy in words, including the head word.
REQ-014 The block SHALL have ports almost_full and almost_empty, output, 1 each, present only under FIFO_ALMOST_FLAGS_EN.

Function
REQ-015 A push SHALL occur on an edge where in_valid && in_ready; a pop SHALL occur on an edge where out_valid && out_ready.
REQ-016 The FIFO SHALL be first-word-fall-through: the head word is visible on out_data whenever out_valid=1, with no request needed.
REQ-017 Capacity SHALL be exactly 2**ADDR_W words; in_ready SHALL equal (count < 2**ADDR_W), registered.
REQ-018 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 Storage SHALL be written at wr_ptr on push; wr_ptr SHALL wrap from 2**ADDR_W-1 to 0.
REQ-020 A storage read (ren=1 at rd_ptr, rd_ptr+1 with wrap) SHALL be issued in a cycle iff at least one unread word is in storage and (out_valid=0 or a pop occurs).
REQ-021 out_valid SHALL be set on the edge that completes a storage read, cleared on a pop with no read issued, and held otherwise.
REQ-022 Latency SHALL be: word pushed into an empty FIFO at edge E0 gives out_valid=1 after edge E1 (two cycles from in_valid to out_valid).
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL be stable (ren held low).
REQ-024 A read SHALL never target the address being written in the same cycle; only words pushed on earlier edges are readable.
REQ-025 in_valid with in_ready=0 SHALL be ignored: no state change and no data loss of stored words.
REQ-026 Back-to-back push and pop SHALL sustain one word per cycle in steady state.

Reset
REQ-027 On rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, almost_empty=1, almost_full=0.
REQ-028 rst SHALL override any same-edge push or pop; storage contents SHALL NOT be cleared; out_data is don't-care while out_valid=0.
REQ-029 Reset mid-operation SHALL discard all stored words; the first push after reset SHALL be the next word output.

Configuration
REQ-030 With FIFO_ALMOST_FLAGS_EN defined, almost_full SHALL be registered (count >= AFULL_TH) and almost_empty registered (count <= AEMPTY_TH), both updated on the same edge as count.
REQ-031 Without FIFO_ALMOST_FLAGS_EN, the ports, parameters' logic and comparators SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold default DATA_W/ADDR_W constants and the occupancy-count type.
REQ-033 Storage SHALL be one sub-module fifo_mem_1024x8: one write port, one read port with registered output and read enable, no reset.

Verification
REQ-034 Reset, push 0xA5 at cycle 0 -> out_valid=1, out_data=0xA5 at cycle 2, count=1.
REQ-035 Push 1024 words 0..255 repeating, out_ready=0 -> in_ready=0 after 1024th push, count=1024; 1025th in_valid ignored.
REQ-036 From full, pop 1024 with out_ready=1 -> exact order preserved across pointer wrap, count=0, out_valid=0.
REQ-037 Steady stream, in_valid=out_ready=1 for 3000 cycles -> one word per cycle, count constant, data in order.
REQ-038 Hold out_ready=0 for 5 cycles with out_valid=1 -> out_data stable; assert rst with 10 words stored -> count=0, out_valid=0 next cycle.
REQ-039 With FIFO_ALMOST_FLAGS_EN, fill to 1016 -> almost_full=1; drain to 8 -> almost_empty=1.
